// File: rtl/regfile.sv
// 32 x 32-bit register file: two combinational read ports, one write port, x0 hardwired to zero.
// Optional same-cycle write-to-read forwarding when REGFILE_BYPASS_EN is defined.
module regfile (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  output logic [31:0] rd1,
  output logic [31:0] rd2,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd,
  output logic [15:0] wr_cnt
);

  logic [31:0] regs_q [32];
  logic [31:0] regs_d [32];
  logic [15:0] wr_cnt_q;
  logic [15:0] wr_cnt_d;
  logic        commit;
  logic [31:0] rd1_stored;
  logic [31:0] rd2_stored;

  // Writes to x0 are dropped entirely, including the counter bump.
  assign commit = we && (wa != 5'd0);

  always_comb begin
    regs_d   = regs_q;
    wr_cnt_d = wr_cnt_q;
    if (commit) begin
      regs_d[wa] = wd;
      wr_cnt_d   = wr_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= 32'h0;
      end
      wr_cnt_q <= 16'h0;
    end else begin
      regs_q   <= regs_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  assign rd1_stored = (ra1 == 5'd0) ? 32'h0 : regs_q[ra1];
  assign rd2_stored = (ra2 == 5'd0) ? 32'h0 : regs_q[ra2];

`ifdef REGFILE_BYPASS_EN
  // Forwarding is suppressed during reset because the pending write will be lost.
  logic fwd1;
  logic fwd2;
  assign fwd1 = rst_n && commit && (ra1 == wa);
  assign fwd2 = rst_n && commit && (ra2 == wa);
  assign rd1  = fwd1 ? wd : rd1_stored;
  assign rd2  = fwd2 ? wd : rd2_stored;
`else
  assign rd1 = rd1_stored;
  assign rd2 = rd2_stored;
`endif

  assign wr_cnt = wr_cnt_q;

endmodule

// File: tb/tb_regfile.sv
// Self-checking bench for regfile: directed literal cases plus randomized traffic against an array model.
module tb_regfile;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  ra1, ra2, wa;
  logic [31:0] rd1, rd2, wd;
  logic        we;
  logic [15:0] wr_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_on  = 1'b0;

  logic [31:0] mdl [32];
  logic [15:0] mdl_cnt = 16'h0;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  regfile dut (
    .clk(clk), .rst_n(rst_n), .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
    .we(we), .wa(wa), .wd(wd), .wr_cnt(wr_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Register file as a plain array: reset clears, committed writes land, counter wraps at 16 bits.
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
      mdl_cnt = 16'h0;
    end else if (we && wa != 5'd0) begin
      mdl[wa] = wd;
      mdl_cnt = mdl_cnt + 16'd1;
    end
  end

  function automatic logic [31:0] exp_rd(input logic [4:0] ra);
    if (ra == 5'd0) return 32'h0;
    if (BYPASS && rst_n && we && wa != 5'd0 && wa == ra) return wd;
    return mdl[ra];
  endfunction

  always @(negedge clk) begin
    if (chk_on) begin
      chk("rd1", rd1, exp_rd(ra1));
      chk("rd2", rd2, exp_rd(ra2));
      chk("wr_cnt", {16'h0, wr_cnt}, {16'h0, mdl_cnt});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] last_wd;

  initial begin
    rst_n = 1'b0; we = 1'b0; wa = 5'd0; wd = 32'h0; ra1 = 5'd0; ra2 = 5'd0;
    tick();
    rst_n = 1'b1;
    chk_on = 1'b1;

    // Post-reset: every address reads zero on both ports.
    for (int a = 0; a < 32; a++) begin
      ra1 = a[4:0];
      ra2 = 5'(31 - a);
      @(negedge clk);
      chk("reset_rd1", rd1, 32'h0);
      chk("reset_rd2", rd2, 32'h0);
      chk("reset_cnt", {16'h0, wr_cnt}, 32'h0);
    end

    @(posedge clk); #1;
    we = 1'b1; wa = 5'd5; wd = 32'hDEADBEEF;
    tick();
    we = 1'b0; ra1 = 5'd5; ra2 = 5'd5;
    @(negedge clk);
    chk("x5_rd1", rd1, 32'hDEADBEEF);
    chk("x5_rd2", rd2, 32'hDEADBEEF);
    chk("x5_cnt", {16'h0, wr_cnt}, 32'd1);

    @(posedge clk); #1;
    we = 1'b1; wa = 5'd0; wd = 32'hFFFFFFFF; ra1 = 5'd0;
    tick();
    we = 1'b0;
    @(negedge clk);
    chk("x0_rd1", rd1, 32'h0);
    chk("x0_cnt", {16'h0, wr_cnt}, 32'd1);

    @(posedge clk); #1;
    we = 1'b1; wa = 5'd7; wd = 32'h12345678; ra2 = 5'd7;
    @(negedge clk);
    chk("x7_same_cycle", rd2, BYPASS ? 32'h12345678 : 32'h0);
    tick();
    we = 1'b0;
    @(negedge clk);
    chk("x7_after_edge", rd2, 32'h12345678);
    chk("x7_cnt", {16'h0, wr_cnt}, 32'd2);

    // Randomized traffic with occasional resets and x0 / read-equals-write biasing.
    @(posedge clk); #1;
    for (int c = 0; c < 3000; c++) begin
      rst_n = ($urandom_range(0, 59) != 0);
      we    = $urandom_range(0, 1);
      wa    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
      wd    = $urandom;
      ra1   = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      ra2   = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      tick();
    end
    rst_n = 1'b1; we = 1'b0;

    // Reset wins over a simultaneous write; reads still show stored data meanwhile.
    we = 1'b1; wa = 5'd3; wd = 32'h11111111;
    tick();
    rst_n = 1'b0; we = 1'b1; wa = 5'd3; wd = 32'hA5A5A5A5; ra1 = 5'd3; ra2 = 5'd7;
    @(negedge clk);
    chk("rst_during_rd1", rd1, 32'h11111111);
    tick();
    rst_n = 1'b1; we = 1'b0;
    @(negedge clk);
    chk("rst_x3", rd1, 32'h0);
    chk("rst_x7", rd2, 32'h0);
    chk("rst_cnt", {16'h0, wr_cnt}, 32'h0);

    // 65536 writes to x1: counter wraps to zero, x1 keeps the final data.
    @(posedge clk); #1;
    ra1 = 5'd1; ra2 = 5'd2; we = 1'b1; wa = 5'd1;
    for (int i = 0; i < 65535; i++) begin
      wd = $urandom;
      tick();
    end
    we = 1'b0;
    @(negedge clk);
    chk("cnt_ffff", {16'h0, wr_cnt}, 32'h0000FFFF);
    @(posedge clk); #1;
    we = 1'b1; last_wd = $urandom; wd = last_wd;
    tick();
    we = 1'b0;
    @(negedge clk);
    chk("cnt_wrap", {16'h0, wr_cnt}, 32'h0);
    chk("x1_last", rd1, last_wd);

    @(posedge clk);
    chk_on = 1'b0;
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
